workout_session_tracker: RTL and testbench



---
 rtl/workout_session_tracker_if.sv | 46 ++++
 rtl/workout_session_tracker.sv | 245 ++++++++++++++++++++++++
 tb/tb_workout_session_tracker.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/workout_session_tracker_if.sv
// Command, sample and status bundle between the sensor front end and the session tracker.
// mst drives commands/samples and observes status; slv is the tracker side.
interface workout_session_tracker_if #(
  parameter int HR_W     = 8,
  parameter int STEP_W   = 2,
  parameter int STRIDE_W = 8,
  parameter int CNT_W    = 16,
  parameter int DIST_W   = 32
);
  logic                start;
  logic                pause;
  logic                stop;
  logic                sample_valid;
  logic [HR_W-1:0]     hr_in;
  logic [STEP_W-1:0]   steps_in;
  logic [STRIDE_W-1:0] stride_cm;

  logic [1:0]          state;
  logic [CNT_W-1:0]    elapsed_s;
  logic [CNT_W-1:0]    total_steps;
  logic [DIST_W-1:0]   total_distance;
  logic [HR_W-1:0]     hr_max;
  logic [HR_W-1:0]     hr_avg;
  logic                hr_avg_valid;
  logic [1:0]          hr_class;
  logic [1:0]          intensity;
  logic [CNT_W-1:0]    zone_s0;
  logic [CNT_W-1:0]    zone_s1;
  logic [CNT_W-1:0]    zone_s2;
  logic                alarm;
  logic                summary_valid;

  modport mst (
    output start, pause, stop, sample_valid, hr_in, steps_in, stride_cm,
    input  state, elapsed_s, total_steps, total_distance, hr_max, hr_avg,
           hr_avg_valid, hr_class, intensity, zone_s0, zone_s1, zone_s2,
           alarm, summary_valid
  );

  modport slv (
    input  start, pause, stop, sample_valid, hr_in, steps_in, stride_cm,
    output state, elapsed_s, total_steps, total_distance, hr_max, hr_avg,
           hr_avg_valid, hr_class, intensity, zone_s0, zone_s1, zone_s2,
           alarm, summary_valid
  );
endinterface

// File: rtl/workout_session_tracker.sv
// Workout session FSM with 1 s tick divider, moving-average HR, zone timers, alarm and saturating totals.
// All outputs registered (sample at edge k visible after edge k); no backpressure, every ACTIVE sample is taken.
module workout_session_tracker #(
  parameter int TICK_DIV  = 50000000,
  parameter int HR_W      = 8,
  parameter int STEP_W    = 2,
  parameter int STRIDE_W  = 8,
  parameter int CNT_W     = 16,
  parameter int DIST_W    = 32,
  parameter int AVG_LOG2  = 3,
  parameter int WARN_BPM  = 150,
  parameter int EMERG_BPM = 180,
  parameter int ZONE1_BPM = 120,
  parameter int ZONE2_BPM = 160,
  parameter int ALARM_CNT = 3
) (
  input logic                     clk,
  input logic                     rst_n,
  workout_session_tracker_if.slv  trk
);

  localparam int N      = 1 << AVG_LOG2;
  localparam int SUM_W  = HR_W + AVG_LOG2;
  localparam int DIV_W  = $clog2(TICK_DIV);
  localparam int ACNT_W = $clog2(ALARM_CNT + 1);
  localparam int FW     = AVG_LOG2 + 1;
  localparam int PROD_W = STEP_W + STRIDE_W;
  localparam int CW1    = CNT_W + 1;
  localparam int DW1    = DIST_W + 1;

  localparam logic [HR_W-1:0]   WARN_T   = HR_W'(WARN_BPM);
  localparam logic [HR_W-1:0]   EMERG_T  = HR_W'(EMERG_BPM);
  localparam logic [HR_W-1:0]   ZONE1_T  = HR_W'(ZONE1_BPM);
  localparam logic [HR_W-1:0]   ZONE2_T  = HR_W'(ZONE2_BPM);
  localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(TICK_DIV - 1);
  localparam logic [ACNT_W-1:0] ALARM_T  = ACNT_W'(ALARM_CNT);
  localparam logic [FW-1:0]     FILL_MAX = FW'(N);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACTIVE = 2'b01,
    S_PAUSED = 2'b10,
    S_DONE   = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic                 new_sess, end_sess, run, accept, tick;

  logic [DIV_W-1:0]     div_q, div_d;
  logic [CNT_W-1:0]     elapsed_q, elapsed_d;
  logic [CNT_W-1:0]     steps_q, steps_d;
  logic [CNT_W-1:0]     zone_q [3];
  logic [CNT_W-1:0]     zone_d [3];
  logic [DIST_W-1:0]    dist_q, dist_d;
  logic [HR_W-1:0]      hr_max_q, hr_max_d;
  logic [HR_W-1:0]      hr_avg_q, hr_avg_d;
  logic                 avg_vld_q, avg_vld_d;
  logic [1:0]           cls_q, cls_d;
  logic [1:0]           int_q, int_d;
  logic [HR_W-1:0]      win_q [N];
  logic [AVG_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic [ACNT_W-1:0]    emerg_q, emerg_d;
  logic                 alarm_q, alarm_d;
  logic                 summary_q;

  logic [CNT_W:0]       steps_sum;
  logic [DIST_W:0]      dist_sum;
  logic [PROD_W-1:0]    prod;

  // Command decode: stop beats pause beats start, evaluated in the registered state.
  always_comb begin
    state_d  = state_q;
    new_sess = 1'b0;
    end_sess = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (trk.start) begin
          state_d  = S_ACTIVE;
          new_sess = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (trk.stop) begin
          state_d  = S_DONE;
          end_sess = 1'b1;
        end else if (trk.pause) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (trk.stop) begin
          state_d  = S_DONE;
          end_sess = 1'b1;
        end else if (trk.start) begin
          state_d = S_ACTIVE;
        end
      end
      default: state_d = state_q;
    endcase
  end

  assign run    = (state_q == S_ACTIVE);
  assign accept = run && trk.sample_valid;
  assign tick   = run && (div_q == DIV_MAX);

  always_comb begin
    div_d     = div_q;
    elapsed_d = elapsed_q;
    steps_d   = steps_q;
    dist_d    = dist_q;
    hr_max_d  = hr_max_q;
    hr_avg_d  = hr_avg_q;
    avg_vld_d = avg_vld_q;
    cls_d     = cls_q;
    int_d     = int_q;
    wr_ptr_d  = wr_ptr_q;
    fill_d    = fill_q;
    sum_d     = sum_q;
    emerg_d   = emerg_q;
    for (int k = 0; k < 3; k++) zone_d[k] = zone_q[k];
    prod      = PROD_W'(trk.steps_in) * PROD_W'(trk.stride_cm);
    steps_sum = {1'b0, steps_q} + CW1'(trk.steps_in);
    dist_sum  = {1'b0, dist_q} + DW1'(prod);

    if (run) div_d = tick ? '0 : div_q + DIV_W'(1);

    // Zone attribution uses the intensity in force before this edge.
    if (tick) begin
      if (elapsed_q != '1) elapsed_d = elapsed_q + CNT_W'(1);
      for (int k = 0; k < 3; k++) begin
        if (int_q == 2'(k) && zone_q[k] != '1) zone_d[k] = zone_q[k] + CNT_W'(1);
      end
    end

    if (accept) begin
      steps_d = steps_sum[CNT_W] ? '1 : steps_sum[CNT_W-1:0];
      dist_d  = dist_sum[DIST_W] ? '1 : dist_sum[DIST_W-1:0];
      if (trk.hr_in > hr_max_q) hr_max_d = trk.hr_in;
      if (trk.hr_in <= WARN_T)       cls_d = 2'b00;
      else if (trk.hr_in <= EMERG_T) cls_d = 2'b01;
      else                           cls_d = 2'b10;

      // Evicted slot holds zero until the window first fills, so the sum stays exact.
      sum_d    = sum_q + SUM_W'(trk.hr_in) - SUM_W'(win_q[wr_ptr_q]);
      wr_ptr_d = wr_ptr_q + AVG_LOG2'(1);
      if (fill_q != FILL_MAX) fill_d = fill_q + FW'(1);
      avg_vld_d = (fill_d == FILL_MAX);
      hr_avg_d  = avg_vld_d ? sum_d[SUM_W-1:AVG_LOG2] : '0;
      if (hr_avg_d < ZONE1_T)       int_d = 2'b00;
      else if (hr_avg_d <= ZONE2_T) int_d = 2'b01;
      else                          int_d = 2'b10;

      if (cls_d == 2'b10) begin
        if (emerg_q != ALARM_T) emerg_d = emerg_q + ACNT_W'(1);
      end else begin
        emerg_d = '0;
      end
    end

    if (end_sess) emerg_d = '0;

    if (new_sess) begin
      div_d     = '0;
      elapsed_d = '0;
      steps_d   = '0;
      dist_d    = '0;
      hr_max_d  = '0;
      hr_avg_d  = '0;
      avg_vld_d = 1'b0;
      cls_d     = 2'b00;
      int_d     = 2'b00;
      wr_ptr_d  = '0;
      fill_d    = '0;
      sum_d     = '0;
      emerg_d   = '0;
      for (int k = 0; k < 3; k++) zone_d[k] = '0;
    end

    alarm_d = (emerg_d >= ALARM_T);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      elapsed_q <= '0;
      steps_q   <= '0;
      dist_q    <= '0;
      hr_max_q  <= '0;
      hr_avg_q  <= '0;
      avg_vld_q <= 1'b0;
      cls_q     <= 2'b00;
      int_q     <= 2'b00;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      sum_q     <= '0;
      emerg_q   <= '0;
      alarm_q   <= 1'b0;
      summary_q <= 1'b0;
      for (int k = 0; k < 3; k++) zone_q[k] <= '0;
      for (int i = 0; i < N; i++) win_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      elapsed_q <= elapsed_d;
      steps_q   <= steps_d;
      dist_q    <= dist_d;
      hr_max_q  <= hr_max_d;
      hr_avg_q  <= hr_avg_d;
      avg_vld_q <= avg_vld_d;
      cls_q     <= cls_d;
      int_q     <= int_d;
      wr_ptr_q  <= wr_ptr_d;
      fill_q    <= fill_d;
      sum_q     <= sum_d;
      emerg_q   <= emerg_d;
      alarm_q   <= alarm_d;
      summary_q <= end_sess;
      for (int k = 0; k < 3; k++) zone_q[k] <= zone_d[k];
      if (new_sess) begin
        for (int i = 0; i < N; i++) win_q[i] <= '0;
      end else if (accept) begin
        win_q[wr_ptr_q] <= trk.hr_in;
      end
    end
  end

  assign trk.state          = state_q;
  assign trk.elapsed_s      = elapsed_q;
  assign trk.total_steps    = steps_q;
  assign trk.total_distance = dist_q;
  assign trk.hr_max         = hr_max_q;
  assign trk.hr_avg         = hr_avg_q;
  assign trk.hr_avg_valid   = avg_vld_q;
  assign trk.hr_class       = cls_q;
  assign trk.intensity      = int_q;
  assign trk.zone_s0        = zone_q[0];
  assign trk.zone_s1        = zone_q[1];
  assign trk.zone_s2        = zone_q[2];
  assign trk.alarm          = alarm_q;
  assign trk.summary_valid  = summary_q;

endmodule

// File: tb/tb_workout_session_tracker.sv
// Directed plus randomized bench for workout_session_tracker against a queue-based session model.
// A second instance with narrow totals exercises saturation from the same stimulus.
module tb_workout_session_tracker;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  workout_session_tracker_if #(.HR_W(8), .STEP_W(2), .STRIDE_W(8), .CNT_W(16), .DIST_W(32)) bus ();
  workout_session_tracker_if #(.HR_W(8), .STEP_W(2), .STRIDE_W(8), .CNT_W(4), .DIST_W(12)) bus2 ();

  assign bus2.start        = bus.start;
  assign bus2.pause        = bus.pause;
  assign bus2.stop         = bus.stop;
  assign bus2.sample_valid = bus.sample_valid;
  assign bus2.hr_in        = bus.hr_in;
  assign bus2.steps_in     = bus.steps_in;
  assign bus2.stride_cm    = bus.stride_cm;

  workout_session_tracker #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .trk(bus)
  );
  workout_session_tracker #(.TICK_DIV(TD), .CNT_W(4), .DIST_W(12)) dut_sat (
    .clk(clk), .rst_n(rst_n), .trk(bus2)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: integers and a queue of the last eight accepted heart rates.
  int     m_state;
  longint m_steps, m_dist, s_steps, s_dist;
  int     m_el, s_el, m_act, m_hmax, m_cls, m_avg, m_int, m_run;
  int     m_z [3];
  bit     m_avld, m_alarm, m_sum;
  int     win [$];

  function automatic longint sat(longint v, longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_session();
    m_steps = 0; m_dist = 0; s_steps = 0; s_dist = 0;
    m_el = 0; s_el = 0; m_act = 0; m_hmax = 0; m_cls = 0;
    m_avg = 0; m_int = 0; m_run = 0; m_avld = 0; m_alarm = 0;
    for (int k = 0; k < 3; k++) m_z[k] = 0;
    win.delete();
  endtask

  task automatic model_edge();
    bit acc, tk;
    int hr, stp, strd, sum;
    acc  = bus.sample_valid && (m_state == 1);
    hr   = int'(bus.hr_in);
    stp  = int'(bus.steps_in);
    strd = int'(bus.stride_cm);
    tk   = 0;
    if (m_state == 1) begin
      m_act++;
      tk = ((m_act % TD) == 0);
    end
    if (tk) begin
      m_el = int'(sat(m_el + 1, 65535));
      s_el = int'(sat(s_el + 1, 15));
      m_z[m_int] = int'(sat(m_z[m_int] + 1, 65535));
    end
    if (acc) begin
      m_steps = sat(m_steps + stp, 65535);
      s_steps = sat(s_steps + stp, 15);
      m_dist  = sat(m_dist + stp * strd, 64'hFFFF_FFFF);
      s_dist  = sat(s_dist + stp * strd, 4095);
      if (hr > m_hmax) m_hmax = hr;
      m_cls = (hr <= 150) ? 0 : (hr <= 180) ? 1 : 2;
      m_run = (m_cls == 2) ? ((m_run < 3) ? m_run + 1 : 3) : 0;
      win.push_back(hr);
      if (win.size() > 8) void'(win.pop_front());
      if (win.size() == 8) begin
        sum = 0;
        foreach (win[i]) sum += win[i];
        m_avg = sum / 8;
        m_avld = 1;
      end else begin
        m_avg = 0;
        m_avld = 0;
      end
      m_int = (m_avg < 120) ? 0 : (m_avg <= 160) ? 1 : 2;
    end
    m_sum = 0;
    case (m_state)
      0, 3: if (bus.start) begin clear_session(); m_state = 1; end
      1: if (bus.stop) begin m_state = 3; m_sum = 1; m_run = 0; end
         else if (bus.pause) m_state = 2;
      2: if (bus.stop) begin m_state = 3; m_sum = 1; m_run = 0; end
         else if (bus.start) m_state = 1;
      default: m_state = m_state;
    endcase
    m_alarm = (m_run >= 3);
  endtask

  task automatic check_all();
    chk("state", 64'(bus.state), 64'(m_state));
    chk("elapsed_s", 64'(bus.elapsed_s), 64'(m_el));
    chk("total_steps", 64'(bus.total_steps), 64'(m_steps));
    chk("total_distance", 64'(bus.total_distance), 64'(m_dist));
    chk("hr_max", 64'(bus.hr_max), 64'(m_hmax));
    chk("hr_avg", 64'(bus.hr_avg), 64'(m_avg));
    chk("hr_avg_valid", 64'(bus.hr_avg_valid), 64'(m_avld));
    chk("hr_class", 64'(bus.hr_class), 64'(m_cls));
    chk("intensity", 64'(bus.intensity), 64'(m_int));
    chk("zone_s0", 64'(bus.zone_s0), 64'(m_z[0]));
    chk("zone_s1", 64'(bus.zone_s1), 64'(m_z[1]));
    chk("zone_s2", 64'(bus.zone_s2), 64'(m_z[2]));
    chk("alarm", 64'(bus.alarm), 64'(m_alarm));
    chk("summary_valid", 64'(bus.summary_valid), 64'(m_sum));
    chk("sat_steps", 64'(bus2.total_steps), 64'(s_steps));
    chk("sat_distance", 64'(bus2.total_distance), 64'(s_dist));
    chk("sat_elapsed", 64'(bus2.elapsed_s), 64'(s_el));
  endtask

  task automatic step(bit st, bit pa, bit sp, bit sv, int hr, int stp, int strd);
    @(negedge clk);
    bus.start        = st;
    bus.pause        = pa;
    bus.stop         = sp;
    bus.sample_valid = sv;
    bus.hr_in        = 8'(hr);
    bus.steps_in     = 2'(stp);
    bus.stride_cm    = 8'(strd);
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int hrs [6];
    bit exp_al [6];
    int r;
    hrs    = '{190, 190, 170, 190, 190, 190};
    exp_al = '{0, 0, 0, 0, 0, 1};
    bus.start = 0; bus.pause = 0; bus.stop = 0; bus.sample_valid = 0;
    bus.hr_in = 0; bus.steps_in = 0; bus.stride_cm = 0;
    m_state = 0; m_sum = 0;
    clear_session();

    repeat (2) @(posedge clk);
    #1 check_all();
    chk("reset_state", 64'(bus.state), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Free-running ACTIVE time with TICK_DIV=4.
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (10) idle();
    chk("elapsed_after_10", 64'(bus.elapsed_s), 64'd2);
    chk("zone0_after_10", 64'(bus.zone_s0), 64'd2);
    chk("active_state", 64'(bus.state), 64'd1);

    // Asynchronous reset mid-cycle takes effect without a clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_state = 0; m_sum = 0;
    clear_session();
    check_all();
    chk("arst_elapsed", 64'(bus.elapsed_s), 64'd0);
    #1 rst_n = 1'b1;

    // Eight identical samples fill the window.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 100, 2, 75);
      if (i == 6) chk("avg_valid_before_full", 64'(bus.hr_avg_valid), 64'd0);
    end
    chk("steps_16", 64'(bus.total_steps), 64'd16);
    chk("dist_1200", 64'(bus.total_distance), 64'd1200);
    chk("avg_100", 64'(bus.hr_avg), 64'd100);
    chk("avg_valid_full", 64'(bus.hr_avg_valid), 64'd1);
    chk("hr_max_100", 64'(bus.hr_max), 64'd100);

    // Window replacement toward 170.
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 170, 1, 50);
    chk("avg_170", 64'(bus.hr_avg), 64'd170);
    chk("intensity_cardio", 64'(bus.intensity), 64'd2);

    // Pause with the coinciding sample accepted, then samples ignored.
    step(0, 1, 0, 1, 100, 1, 10);
    for (int i = 0; i < 20; i++)
      step(0, 0, 0, 1, $urandom_range(60, 220), $urandom_range(0, 3), $urandom_range(0, 255));
    chk("paused_state", 64'(bus.state), 64'd2);
    step(1, 0, 0, 1, 200, 3, 200);
    repeat (3) idle();

    // Sustained emergency.
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1, hrs[i], 1, 60);
      chk($sformatf("alarm_seq_%0d", i), 64'(bus.alarm), 64'(exp_al[i]));
    end
    step(0, 0, 1, 0, 0, 0, 0);
    chk("stop_alarm_clear", 64'(bus.alarm), 64'd0);
    chk("stop_done", 64'(bus.state), 64'd3);
    chk("stop_summary", 64'(bus.summary_valid), 64'd1);
    idle();
    chk("summary_one_cycle", 64'(bus.summary_valid), 64'd0);

    // Randomized sessions.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      step(r < 3, (r >= 3) && (r < 6), r == 6, $urandom_range(0, 3) != 0,
           $urandom_range(60, 220), $urandom_range(0, 3), $urandom_range(0, 255));
    end

    // Saturation on the narrow instance.
    step(0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 120, 3, 200);
    chk("sat_steps_15", 64'(bus2.total_steps), 64'd15);
    chk("sat_dist_3600", 64'(bus2.total_distance), 64'd3600);
    step(0, 0, 0, 1, 120, 3, 255);
    chk("sat_dist_4095", 64'(bus2.total_distance), 64'd4095);
    chk("main_dist_4365", 64'(bus.total_distance), 64'd4365);

    // stop+pause+start together in ACTIVE: stop wins, sample still taken.
    step(1, 1, 1, 1, 200, 1, 10);
    chk("combo_done", 64'(bus.state), 64'd3);
    chk("combo_summary", 64'(bus.summary_valid), 64'd1);
    chk("combo_steps_22", 64'(bus.total_steps), 64'd22);
    chk("combo_hr_max", 64'(bus.hr_max), 64'd200);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
